uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter: serialises one word per ready/valid handshake into an asynchronous frame with a start bit, configurable data width, optional parity and one or two stop bits. It runs on the system clock with an internal bit-period divider, so no separate baud clock is needed. It supersedes the fixed 8N1 transmitter and sits between a byte/word producer (FIFO or register interface) and the board TX pin.

## Interface
- CLK_DIV, 868 — system clocks per bit period; ≥ 2.
- DATA_BITS, 8 — data bits per frame; legal 5..9.
- PARITY, 0 — 0 none, 1 odd, 2 even.
- STOP_BITS, 1 — 1 or 2.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  transmitter accepts a word this cycle.
- tx_data  in  DATA_BITS  word to send, LSB first.
- tx_out  out  1  serial line; idles high.
- busy  out  1  frame in progress (start through last stop bit).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, tx_ready=1, busy=0. On tx_valid&&tx_ready, latch tx_data into shift register, compute parity, enter START.
- START: tx_out=0 for CLK_DIV cycles → DATA.
- DATA: tx_out = shift[0]; after CLK_DIV cycles shift right, bit index +1; after DATA_BITS bits → PARITY if PARITY≠0, else STOP.
- PARITY: tx_out = ^data (even) or ~^data (odd), computed from the latched word; CLK_DIV cycles → STOP.
- STOP: tx_out=1 for STOP_BITS×CLK_DIV cycles → IDLE, or directly START if a word is accepted in its final cycle.
- tx_ready = IDLE, or STOP in its final cycle (last stop bit, divider = CLK_DIV−1). Acceptance in that cycle gives back-to-back frames with no idle gap.
- tx_valid while tx_ready=0: ignored; producer holds it. tx_data changes after acceptance have no effect.
- Divider: counter of width $clog2(CLK_DIV), cleared on acceptance and at each bit boundary. Bit index of width $clog2(DATA_BITS+1). No overflow; every bit is exactly CLK_DIV cycles.
- busy = state≠IDLE.

## Timing
- Reset (rst_n=0 at an edge): next cycle state=IDLE, tx_out=1, tx_ready=1, busy=0, counters 0. Applies mid-frame: the frame is aborted and the line returns high immediately. No partial resume.
- Acceptance at edge N: tx_out=0 from cycle N+1. Frame length is exactly CLK_DIV×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- Outputs tx_out and busy are registered. tx_ready is decoded from registered state only, with no combinational path from tx_valid.
- Parameter violations (CLK_DIV<2, DATA_BITS outside 5..9, STOP_BITS∉{1,2}, PARITY>2) are caught by elaboration-time check.

## Structure
- Shared package uart_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP) and parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2, for reuse by the planned configurable receiver.
- One sub-module, uart_bit_timer:
  - parameter CLK_DIV; inputs restart and enable.
  - output bit_done, a one-cycle pulse at divider = CLK_DIV−1.
- The FSM, shift register and parity live in uart_tx_cfg.

## Test plan
- CLK_DIV=4, 8 data bits, even parity, 1 stop; send 0xA5 → tx_out bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. Frame is 44 cycles; busy high throughout, tx_ready high only in the last cycle.
- Odd parity, send 0x07 → parity bit 0. Send 0x03 → parity bit 1.
- DATA_BITS=7, PARITY none, STOP_BITS=2, CLK_DIV=4; send 0x55 → 0,1,0,1,0,1,0,1,1,1. Frame is 40 cycles; tx_out high after.
- Back-to-back: hold tx_valid with 0x00 then 0xFF → the second start bit begins on the cycle directly after the first frame's last stop cycle, with no idle-high gap. Changing tx_data mid-frame does not alter bits.
- Reset mid-frame: assert rst_n=0 during data bit 3 → next cycle tx_out=1, tx_ready=1, busy=0. A new word afterwards produces a clean full frame.
- tx_valid pulsed while busy → ignored: no extra frame and line unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the parity helper.
// Used by the configurable transmitter and intended for reuse by the matching receiver.
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 32'd0;
    localparam int unsigned PAR_ODD  = 32'd1;
    localparam int unsigned PAR_EVEN = 32'd2;

    localparam int unsigned MAX_DATA_BITS = 32'd9;

    // Zero-extended upper bits do not change the XOR, so any legal width can share this.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned mode);
        logic ones_odd;
        ones_odd = ^data;
        case (mode)
            PAR_ODD:  calc_parity = ~ones_odd;
            PAR_EVEN: calc_parity = ones_odd;
            default:  calc_parity = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts system clocks while enabled and pulses bit_done on the
// last clock of each bit period. restart clears the count so a new frame starts aligned.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 32'd868
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic bit_done
);

    localparam int unsigned      CNT_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = enable && (cnt_q == CNT_LAST);

    // Next divider value: clear on restart or bit boundary, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (bit_done) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(32'd1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider register with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first, optional parity,
// one or two stop bits, with an internal divider so no separate baud clock is needed.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 32'd868,
    parameter int unsigned DATA_BITS = 32'd8,
    parameter int unsigned PARITY    = 32'd0,
    parameter int unsigned STOP_BITS = 32'd1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 busy
);

    localparam int unsigned      IDX_W         = $clog2(DATA_BITS + 32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 32'd1);

    if (CLK_DIV < 32'd2) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be at least 2");
    end
    if ((DATA_BITS < 32'd5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    uart_state_e            state_q;
    uart_state_e            state_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [IDX_W-1:0]       bit_idx_d;
    logic                   par_q;
    logic                   par_d;
    logic                   tx_out_q;
    logic                   tx_out_d;
    logic                   busy_q;
    logic                   busy_d;

    logic                   bit_done_s;
    logic                   timer_en_s;
    logic                   last_stop_s;
    logic                   accept_s;
    logic [MAX_DATA_BITS-1:0] data_ext_s;

    assign timer_en_s  = (state_q != ST_IDLE);
    assign last_stop_s = (state_q == ST_STOP) && bit_done_s && (bit_idx_q == IDX_LAST_STOP);
    assign tx_ready    = (state_q == ST_IDLE) || last_stop_s;
    assign accept_s    = tx_valid && tx_ready;
    assign data_ext_s  = MAX_DATA_BITS'(tx_data);

    assign tx_out = tx_out_q;
    assign busy   = busy_q;

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .restart  (accept_s),
        .enable   (timer_en_s),
        .bit_done (bit_done_s)
    );

    // Frame sequencing: next state, shift register, bit/stop index and next line level.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        tx_out_d  = tx_out_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    par_d     = calc_parity(data_ext_s, PARITY);
                    bit_idx_d = '0;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    tx_out_d  = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_out_d  = shift_q[0];
                end else begin
                    state_d   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_idx_q == IDX_LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d  = ST_PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d  = ST_STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(32'd1);
                        tx_out_d  = shift_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_out_d  = 1'b1;
                end else begin
                    state_d   = ST_PARITY;
                end
            end
            ST_STOP: begin
                // A word accepted in the final stop cycle starts the next frame with no gap.
                if (accept_s) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    par_d     = calc_parity(data_ext_s, PARITY);
                    bit_idx_d = '0;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end else if (last_stop_s) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                    tx_out_d  = 1'b1;
                    busy_d    = 1'b0;
                end else if (bit_done_s) begin
                    bit_idx_d = bit_idx_q + IDX_W'(32'd1);
                end else begin
                    state_d   = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                tx_out_d  = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: several parameter sets run side by side, each with a
// driver pushing expected frames and a monitor checking the line cycle by cycle.
module tb_uart_tx_cfg;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int NCFG   = 5;
    localparam int NWORDS = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done_v [NCFG];

    typedef struct {
        int         start;
        int         nbits;
        logic [15:0] bits;
    } frame_t;

    // {CLK_DIV, DATA_BITS, PARITY, STOP_BITS}
    function automatic logic [31:0] cfg_word(input int i);
        case (i)
            0:       return {8'd4, 8'd8, 8'd2, 8'd1};
            1:       return {8'd4, 8'd8, 8'd1, 8'd1};
            2:       return {8'd4, 8'd7, 8'd0, 8'd2};
            3:       return {8'd2, 8'd9, 8'd1, 8'd2};
            4:       return {8'd5, 8'd5, 8'd2, 8'd1};
            default: return {8'd4, 8'd8, 8'd0, 8'd1};
        endcase
    endfunction

    function automatic int unsigned dir_word(input int w);
        case (w)
            0:       return 32'hA5;
            1:       return 32'h07;
            2:       return 32'h03;
            3:       return 32'h55;
            4:       return 32'h00;
            5:       return 32'hFF;
            default: return 32'h00;
        endcase
    endfunction

    // Reference frame: start 0, data LSB first, parity from a ones count, then stop 1s.
    function automatic frame_t make_frame(input int db, input int par, input int sb,
                                          input int unsigned d, input int start);
        frame_t f;
        int n;
        int ones;
        f.bits  = 16'h0;
        f.start = start;
        n       = 0;
        ones    = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int k = 0; k < db; k++) begin
            f.bits[n] = ((d >> k) & 1) != 0;
            ones += int'((d >> k) & 1);
            n++;
        end
        if (par != 0) begin
            f.bits[n] = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        for (int k = 0; k < sb; k++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    task automatic chk(input int inst, input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s at cycle %0d: got %b expected %b", inst, name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input int inst, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s at cycle %0d: got %0d expected %0d", inst, name, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam logic [31:0] CW  = cfg_word(gi);
        localparam int          CD  = int'(CW[31:24]);
        localparam int          DB  = int'(CW[23:16]);
        localparam int          PAR = int'(CW[15:8]);
        localparam int          SB  = int'(CW[7:0]);
        localparam int          FL  = CD * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

        logic          rst_n;
        logic          tx_valid;
        logic          tx_ready;
        logic [DB-1:0] tx_data;
        logic          tx_out;
        logic          busy;
        frame_t        exp_q[$];

        uart_tx_cfg #(
            .CLK_DIV   (CD),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB)
        ) u_dut (
            .sys_clk  (clk),
            .rst_n    (rst_n),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .tx_data  (tx_data),
            .tx_out   (tx_out),
            .busy     (busy)
        );

        initial begin : mon
            frame_t cur;
            bit     in_frame;
            int     idx;
            in_frame = 1'b0;
            cur      = '{start: 0, nbits: 0, bits: 16'h0};
            forever begin
                @(posedge clk);
                #1;
                if (rst_n !== 1'b1) begin
                    exp_q.delete();
                    in_frame = 1'b0;
                    chk(gi, "reset tx_out", tx_out, 1'b1);
                    chk(gi, "reset tx_ready", tx_ready, 1'b1);
                    chk(gi, "reset busy", busy, 1'b0);
                end else begin
                    if (!in_frame && exp_q.size() > 0 && exp_q[0].start < cyc) begin
                        chk_int(gi, "frame start cycle", cyc, exp_q[0].start);
                        void'(exp_q.pop_front());
                    end
                    if (!in_frame && exp_q.size() > 0 && exp_q[0].start == cyc) begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                    end
                    if (in_frame) begin
                        idx = cyc - cur.start;
                        chk(gi, "tx_out frame bit", tx_out, cur.bits[idx / CD]);
                        chk(gi, "busy in frame", busy, 1'b1);
                        chk(gi, "tx_ready in frame", tx_ready, idx == cur.nbits * CD - 1);
                        if (idx == cur.nbits * CD - 1) begin
                            in_frame = 1'b0;
                        end
                    end else begin
                        chk(gi, "idle tx_out", tx_out, 1'b1);
                        chk(gi, "idle tx_ready", tx_ready, 1'b1);
                        chk(gi, "idle busy", busy, 1'b0);
                    end
                end
            end
        end

        task automatic send_word(input int unsigned d, output int start);
            int wt;
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = DB'(d);
            wt       = 0;
            while (tx_ready !== 1'b1 && wt < 4 * FL) begin
                @(negedge clk);
                wt++;
            end
            chk(gi, "handshake ready", tx_ready, 1'b1);
            start = cyc + 1;
            if (tx_ready === 1'b1) begin
                exp_q.push_back(make_frame(DB, PAR, SB, d, start));
            end
        endtask

        initial begin : drv
            int unsigned d;
            int unsigned mask;
            int          gap;
            int          wt;
            int          s;
            mask     = (32'd1 << DB) - 32'd1;
            rst_n    = 1'b0;
            tx_valid = 1'b0;
            tx_data  = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int w = 0; w < NWORDS; w++) begin
                d   = ((w < 6) ? dir_word(w) : $urandom) & mask;
                gap = (w == 5 || $urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2 * FL));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    tx_data  = DB'($urandom);
                    tx_valid = (tx_ready !== 1'b1) && ($urandom_range(0, 3) == 0);
                end
                send_word(d, s);
            end
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (FL) @(negedge clk);

            send_word($urandom & mask, s);
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = DB'($urandom);
            while (cyc < s + 4 * CD) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            send_word($urandom & mask, s);
            @(negedge clk);
            tx_valid = 1'b0;

            wt = 0;
            while ((exp_q.size() != 0 || busy !== 1'b0) && wt < 4 * FL) begin
                @(negedge clk);
                wt++;
            end
            chk_int(gi, "expected frames drained", exp_q.size(), 0);
            done_v[gi] = 1'b1;
        end
    end

    initial begin : main
        int wt;
        int ndone;
        wt    = 0;
        ndone = 0;
        while (ndone < NCFG && wt < 90000) begin
            @(negedge clk);
            wt++;
            ndone = 0;
            for (int i = 0; i < NCFG; i++) begin
                ndone += int'(done_v[i]);
            end
        end
        chk_int(-1, "instances completed", ndone, NCFG);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
